// File: rtl/div_pkg.sv
// Shared types, opcodes and constants for the divider issue controller.
package div_pkg;
    localparam int XLEN = 64;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] extend_word(input logic [XLEN-1:0] v, input logic sign_ext);
        return sign_ext ? {{(XLEN-32){v[31]}}, v[31:0]} : {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    // W forms always sign-extend the 32-bit result, unsigned ones included.
    function automatic logic [XLEN-1:0] select_result(input logic [XLEN-1:0] q,
                                                      input logic [XLEN-1:0] r,
                                                      input logic is_rem,
                                                      input logic word);
        logic [XLEN-1:0] sel;
        sel = is_rem ? r : q;
        return word ? extend_word(sel, 1'b1) : sel;
    endfunction
endpackage

// File: rtl/div_special_detect.sv
// Flags divide-by-zero and signed overflow on prepared operands and
// supplies the architecturally defined quotient/remainder for them.
module div_special_detect
    import div_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    input  logic            word,
    output logic            is_div0,
    output logic            is_ovf,
    output logic [XLEN-1:0] bypass_q,
    output logic [XLEN-1:0] bypass_r
);
    logic ovf_word;
    logic ovf_full;

    assign is_div0  = (b == '0);
    assign ovf_word = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    assign ovf_full = (a == MOST_NEG) && (b == ALL_ONES);
    assign is_ovf   = is_signed && (word ? ovf_word : ovf_full);

    // Overflow keeps the dividend as quotient; the two cases never overlap.
    assign bypass_q = is_div0 ? ALL_ONES : a;
    assign bypass_r = is_div0 ? a : '0;
endmodule

// File: rtl/div_sched_ctrl.sv
// Issue controller for the shared iterative divider: decode, operand prep,
// special-case bypass and core sequencing. DIV_RESULT_CACHE_EN adds a one-entry result cache.
module div_sched_ctrl #(
    parameter int XLEN        = 64,
    parameter int DIV_TIMEOUT = 127
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            err_timeout,
    output logic            div_in_valid,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    output logic            div_signed,
    output logic            div_flush,
    input  logic            div_result_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);
    import div_pkg::*;

    localparam int CW = $clog2(DIV_TIMEOUT + 1);

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            signed_q, signed_d, word_q, word_d, rem_q, rem_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            err_timeout_q, err_timeout_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

    logic            is_div0, is_ovf, bypass, cache_hit, core_done;
    logic [XLEN-1:0] bypass_q, bypass_r, hit_q, hit_r;

    div_special_detect u_detect (
        .a         (a_q),
        .b         (b_q),
        .is_signed (signed_q),
        .word      (word_q),
        .is_div0   (is_div0),
        .is_ovf    (is_ovf),
        .bypass_q  (bypass_q),
        .bypass_r  (bypass_r)
    );

    assign bypass    = is_div0 | is_ovf;
    assign cnt_inc   = cnt_q + 1'b1;
    assign core_done = (state_q == BUSY) && !flush && div_result_valid;

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_valid_q, cache_valid_d, cache_signed_q, cache_signed_d;
    logic [XLEN-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
    logic [XLEN-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

    assign cache_hit = cache_valid_q && (cache_a_q == a_q) && (cache_b_q == b_q)
                       && (cache_signed_q == signed_q);
    assign hit_q = cache_quo_q;
    assign hit_r = cache_rem_q;

    always_comb begin
        cache_valid_d  = cache_valid_q;
        cache_signed_d = cache_signed_q;
        cache_a_d      = cache_a_q;
        cache_b_d      = cache_b_q;
        cache_quo_d    = cache_quo_q;
        cache_rem_d    = cache_rem_q;
        if (core_done) begin
            cache_valid_d  = 1'b1;
            cache_signed_d = signed_q;
            cache_a_d      = a_q;
            cache_b_d      = b_q;
            cache_quo_d    = div_quotient;
            cache_rem_d    = div_remainder;
        end
    end

    // Only reset invalidates; a flushed or timed-out op never reaches core_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q  <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
        end else begin
            cache_valid_q  <= cache_valid_d;
            cache_signed_q <= cache_signed_d;
            cache_a_q      <= cache_a_d;
            cache_b_q      <= cache_b_d;
            cache_quo_q    <= cache_quo_d;
            cache_rem_q    <= cache_rem_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_q     = '0;
    assign hit_r     = '0;
`endif

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        signed_d      = signed_q;
        word_d        = word_q;
        rem_d         = rem_q;
        rsp_data_d    = rsp_data_q;
        cnt_d         = cnt_q;
        err_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    signed_d = (req_op == OP_DIV) || (req_op == OP_REM);
                    rem_d    = (req_op == OP_REM) || (req_op == OP_REMU);
                    word_d   = req_word;
                    a_d      = req_word ? extend_word(req_a, signed_d) : req_a;
                    b_d      = req_word ? extend_word(req_b, signed_d) : req_b;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (bypass) begin
                    rsp_data_d = select_result(bypass_q, bypass_r, rem_q, word_q);
                    state_d    = DONE;
                end else if (cache_hit) begin
                    rsp_data_d = select_result(hit_q, hit_r, rem_q, word_q);
                    state_d    = DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (div_result_valid) begin
                    rsp_data_d = select_result(div_quotient, div_remainder, rem_q, word_q);
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(DIV_TIMEOUT)) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            DONE: begin
                if (flush || rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == DONE);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            signed_q      <= 1'b0;
            word_q        <= 1'b0;
            rem_q         <= 1'b0;
            rsp_data_q    <= '0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            signed_q      <= signed_d;
            word_q        <= word_d;
            rem_q         <= rem_d;
            rsp_data_q    <= rsp_data_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Start and abort track the live state so a flush in CHECK never starts the core.
    assign div_in_valid = (state_q == CHECK) && !flush && !bypass && !cache_hit;
    assign div_flush    = err_timeout_q || (flush && ((state_q == CHECK) || (state_q == BUSY)));

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign err_timeout = err_timeout_q;
    assign div_a       = a_q;
    assign div_b       = b_q;
    assign div_signed  = signed_q;
endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed bench for div_sched_ctrl with a fixed-latency divider core model.
module tb_div_sched_ctrl;
    logic        clk, reset;
    logic        req_valid, req_ready, req_word, flush;
    logic [1:0]  req_op;
    logic [63:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, err_timeout;
    logic [63:0] rsp_data;
    logic        div_in_valid, div_signed, div_flush, div_result_valid;
    logic [63:0] div_a, div_b, div_quotient, div_remainder;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int core_lat  = 3;
    bit core_hang = 0;
    bit inject    = 0;

`ifdef DIV_RESULT_CACHE_EN
    localparam int REPEAT_LAT = 2;
`else
    localparam int REPEAT_LAT = 6;
`endif

    div_sched_ctrl #(.XLEN(64), .DIV_TIMEOUT(127)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err_timeout(err_timeout),
        .div_in_valid(div_in_valid), .div_a(div_a), .div_b(div_b),
        .div_signed(div_signed), .div_flush(div_flush),
        .div_result_valid(div_result_valid), .div_quotient(div_quotient),
        .div_remainder(div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: result core_lat cycles after the start pulse, computed from live inputs.
    initial begin
        bit     pend;
        int     lat;
        longint sa, sb;
        pend = 0; lat = 0;
        div_result_valid = 1'b0; div_quotient = '0; div_remainder = '0;
        forever begin
            @(negedge clk);
            div_result_valid = 1'b0;
            if (reset || div_flush) begin
                pend = 0;
            end else if (div_in_valid) begin
                start_cnt++; pend = 1; lat = core_lat;
            end else if (inject) begin
                div_result_valid = 1'b1; div_quotient = 64'h1234; div_remainder = 64'h5678;
            end else if (pend && !core_hang) begin
                if (lat == 0) begin
                    sa = div_a; sb = div_b;
                    if (div_b == 64'd0) begin
                        div_quotient = '1; div_remainder = div_a;
                    end else if (div_signed && div_a == 64'h8000_0000_0000_0000 && div_b == '1) begin
                        div_quotient = div_a; div_remainder = '0;
                    end else if (div_signed) begin
                        div_quotient = sa / sb; div_remainder = sa % sb;
                    end else begin
                        div_quotient = div_a / div_b; div_remainder = div_a % div_b;
                    end
                    div_result_valid = 1'b1; pend = 0;
                end else begin
                    lat--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t want finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
        req_op = op; req_word = word; req_a = a; req_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Returns the cycle (acceptance = 0) at which rsp_valid is seen, or limit on expiry.
    task automatic wait_rsp(input int limit, output int k);
        k = 1;
        while (!rsp_valid && k < limit) begin
            tick(); k++;
        end
    endtask

    task automatic take();
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 0; req_op = 0; req_word = 0; req_a = 0; req_b = 0;
        flush = 0; rsp_ready = 0;
        repeat (3) tick();
        reset = 1'b0; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_data !== 64'd0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
        total++; if ({err_timeout, div_in_valid, div_flush, div_signed} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl_outs got=%b want=0000", {err_timeout, div_in_valid, div_flush, div_signed}); end
        total++; if ({div_a, div_b} !== 128'd0) begin bad++; $display("FAIL reset_div_ab got=%h/%h want=0/0", div_a, div_b); end
        tick();
        $display("reset: done");
    endtask

    task automatic test_signed_div();
        int k, s0;
        core_lat = 3; s0 = start_cnt;
        issue(2'b00, 1'b0, -64'sd7, 64'd2);
        wait_rsp(50, k);
        total++; if (k !== 6) begin bad++; $display("FAIL div_m7_2_latency got=%0d want=6", k); end
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_m7_2_data got=%h want=fffffffffffffffd", rsp_data); end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL div_m7_2_starts got=%0d want=1", start_cnt - s0); end
        total++; if (div_a !== 64'hFFFF_FFFF_FFFF_FFF9 || div_signed !== 1'b1) begin
            bad++; $display("FAIL div_m7_2_held got=%h/%b want=fffffffffffffff9/1", div_a, div_signed); end
        take();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL div_m7_2_ready_after got=%b want=1", req_ready); end
        $display("DIV -7/2 -> %h", rsp_data);
        issue(2'b10, 1'b0, -64'sd7, 64'd2);
        wait_rsp(50, k);
        total++; if (k !== REPEAT_LAT) begin bad++; $display("FAIL rem_m7_2_latency got=%0d want=%0d", k, REPEAT_LAT); end
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rem_m7_2_data got=%h want=ffffffffffffffff", rsp_data); end
        $display("REM -7%%2 -> %h", rsp_data);
        take();
    endtask

    task automatic test_div_zero();
        int k, s0;
        s0 = start_cnt;
        issue(2'b01, 1'b0, 64'd5, 64'd0);
        wait_rsp(50, k);
        total++; if (k !== 2) begin bad++; $display("FAIL divu_5_0_latency got=%0d want=2", k); end
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL divu_5_0_data got=%h want=ffffffffffffffff", rsp_data); end
        $display("DIVU 5/0 -> %h", rsp_data);
        take();
        issue(2'b11, 1'b0, 64'd5, 64'd0);
        wait_rsp(50, k);
        total++; if (rsp_data !== 64'd5 || k !== 2) begin bad++; $display("FAIL remu_5_0 got=%h@%0d want=5@2", rsp_data, k); end
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL div0_no_start got=%0d want=%0d", start_cnt, s0); end
        $display("REMU 5%%0 -> %h", rsp_data);
        take();
    endtask

    task automatic test_overflow();
        int k, s0;
        s0 = start_cnt;
        issue(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_rsp(50, k);
        total++; if (rsp_data !== 64'h8000_0000_0000_0000 || k !== 2) begin
            bad++; $display("FAIL div_ovf got=%h@%0d want=8000000000000000@2", rsp_data, k); end
        $display("DIV ovf -> %h", rsp_data);
        take();
        issue(2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        wait_rsp(50, k);
        total++; if (rsp_data !== 64'd0 || k !== 2) begin bad++; $display("FAIL remw_ovf got=%h@%0d want=0@2", rsp_data, k); end
        $display("REMW ovf -> %h", rsp_data);
        take();
        issue(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
        wait_rsp(50, k);
        total++; if (rsp_data !== 64'hFFFF_FFFF_8000_0000 || k !== 2) begin
            bad++; $display("FAIL divw_ovf got=%h@%0d want=ffffffff80000000@2", rsp_data, k); end
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL ovf_no_start got=%0d want=%0d", start_cnt, s0); end
        $display("DIVW ovf -> %h", rsp_data);
        take();
    endtask

    task automatic test_word_unsigned();
        int k;
        issue(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
        total++; if (div_a !== 64'h0000_0000_FFFF_FFFE || div_signed !== 1'b0 || div_in_valid !== 1'b1) begin
            bad++; $display("FAIL divuw_operands got=%h/%b/%b want=00000000fffffffe/0/1", div_a, div_signed, div_in_valid); end
        wait_rsp(50, k);
        total++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFE || k !== 6) begin
            bad++; $display("FAIL divuw_data got=%h@%0d want=fffffffffffffffe@6", rsp_data, k); end
        $display("DIVUW -> %h", rsp_data);
        take();
    endtask

    task automatic test_flush();
        int k, seen, s0;
        core_lat = 20; s0 = start_cnt;
        issue(2'b00, 1'b0, 64'd100, 64'd7);
        repeat (11) tick();
        flush = 1'b1; #1;
        total++; if (div_flush !== 1'b1) begin bad++; $display("FAIL flush_div_flush got=%b want=1", div_flush); end
        tick();
        flush = 1'b0; #1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL flush_idle got=ready%b/valid%b want=ready1/valid0", req_ready, rsp_valid); end
        seen = 0;
        repeat (15) begin tick(); if (rsp_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_rsp got=%0d want=0", seen); end
        core_lat = 3;
        issue(2'b00, 1'b0, 64'd100, 64'd7);
        wait_rsp(50, k);
        total++; if (rsp_data !== 64'd14 || k !== 6) begin bad++; $display("FAIL div_100_7 got=%0d@%0d want=14@6", rsp_data, k); end
        total++; if (start_cnt - s0 !== 2) begin bad++; $display("FAIL flush_starts got=%0d want=2", start_cnt - s0); end
        $display("flush then DIV 100/7 -> %0d", rsp_data);
        take();
    endtask

    task automatic test_flush_corners();
        int k, s0;
        s0 = start_cnt;
        req_op = 2'b00; req_word = 0; req_a = 64'd100; req_b = 64'd7;
        req_valid = 1'b1; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_with_req_ready got=%b want=1", req_ready); end
        tick();
        total++; if (rsp_valid !== 1'b0 || start_cnt !== s0) begin
            bad++; $display("FAIL flush_with_req_ignored got=valid%b/starts%0d want=0/%0d", rsp_valid, start_cnt, s0); end
        issue(2'b01, 1'b0, 64'd9, 64'd0);
        wait_rsp(50, k);
        flush = 1'b1; rsp_ready = 1'b1;
        tick();
        flush = 1'b0; rsp_ready = 1'b0; #1;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL done_flush_ready got=valid%b/ready%b want=0/1", rsp_valid, req_ready); end
        issue(2'b11, 1'b0, 64'd9, 64'd0);
        wait_rsp(50, k);
        total++; if (rsp_data !== 64'd9 || k !== 2) begin bad++; $display("FAIL after_done_flush got=%h@%0d want=9@2", rsp_data, k); end
        take();
        inject = 1'b1; tick(); inject = 1'b0; tick();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL idle_result_ignored got=valid%b/ready%b want=0/1", rsp_valid, req_ready); end
        $display("flush corners: done");
    endtask

    task automatic test_timeout();
        int k, seen;
        core_hang = 1'b1; seen = 0;
        issue(2'b00, 1'b0, 64'd9, 64'd3);
        k = 1;
        while (!err_timeout && k < 300) begin
            tick(); k++;
            if (rsp_valid) seen++;
        end
        total++; if (k !== 129) begin bad++; $display("FAIL timeout_cycle got=%0d want=129", k); end
        total++; if (div_flush !== 1'b1 || req_ready !== 1'b1 || seen !== 0) begin
            bad++; $display("FAIL timeout_outs got=flush%b/ready%b/rsp%0d want=1/1/0", div_flush, req_ready, seen); end
        tick();
        total++; if (err_timeout !== 1'b0 || div_flush !== 1'b0) begin
            bad++; $display("FAIL timeout_pulse got=%b/%b want=0/0", err_timeout, div_flush); end
        core_hang = 1'b0;
        $display("timeout after %0d cycles", k);
    endtask

    task automatic test_hold();
        int k, err;
        core_lat = 3; err = 0;
        issue(2'b00, 1'b0, 64'd9, 64'd3);
        wait_rsp(50, k);
        total++; if (rsp_data !== 64'd3 || k !== 6) begin bad++; $display("FAIL hold_first got=%0d@%0d want=3@6", rsp_data, k); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (rsp_data !== 64'd3 || req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
                bad++; $display("FAIL hold_cycle%0d got=%0d/ready%b/valid%b want=3/0/1", i, rsp_data, req_ready, rsp_valid);
            end
        end
        take();
        $display("hold: done");
    endtask

    task automatic test_reset_mid();
        core_lat = 20;
        issue(2'b00, 1'b0, 64'd100, 64'd7);
        repeat (4) tick();
        reset = 1'b1; tick(); reset = 1'b0; #1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || div_a !== 64'd0 || div_signed !== 1'b0) begin
            bad++; $display("FAIL reset_mid got=ready%b/valid%b/a%h/s%b want=1/0/0/0", req_ready, rsp_valid, div_a, div_signed); end
        core_lat = 3;
        tick();
        $display("reset mid-op: done");
    endtask

    initial begin
        test_reset();
        test_signed_div();
        test_div_zero();
        test_overflow();
        test_word_unsigned();
        test_flush();
        test_flush_corners();
        test_timeout();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
